row_checker: RTL

ROW_CHECKER -- requirements
Module: row_checker

---
 rtl/row_checker_pkg.sv | 23 ++
 rtl/row_checker_data.sv | 52 +++++
 rtl/row_checker.sv | 116 +++++++++++
 3 files changed

// File: rtl/row_checker_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// row_checker_pkg : shared tetris board geometry, coordinate/cell types
// Revision: 1.0
// ---------------------------------------------------------------------------
package row_checker_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;

  typedef logic [4:0] coord_t;
  typedef logic [2:0] cell_id_t;

  localparam cell_id_t EMPTY_ID = 3'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/row_checker_data.sv
`default_nettype none
// ---------------------------------------------------------------------------
// row_checker_data : latched row, column counter and read valid/tag pipeline
// Revision: 1.0
// ---------------------------------------------------------------------------
module row_checker_data
  import row_checker_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   load,
  input  logic   advance,
  input  logic   abort,
  input  logic   rden,
  input  coord_t row,
  output coord_t row_q,
  output coord_t x,
  output logic   valid_q,
  output coord_t tag_q
);

  coord_t r_row_q;
  coord_t r_x;
  logic   r_valid;
  coord_t r_tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_row_q <= '0;
      r_x     <= '0;
      r_valid <= 1'b0;
      r_tag   <= '0;
    end else begin
      // Counter only moves while a read is being issued, so it doubles as read_x.
      if (load) begin
        r_row_q <= row;
        r_x     <= '0;
      end else if (advance) begin
        r_x     <= r_x + coord_t'(1);
      end
      r_valid <= rden & ~abort;
      r_tag   <= r_x;
    end
  end

  assign row_q   = r_row_q;
  assign x       = r_x;
  assign valid_q = r_valid;
  assign tag_q   = r_tag;

endmodule
`default_nettype wire

// File: rtl/row_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// row_checker : scans one board row and reports whether every cell is filled
// Revision: 1.0
// ---------------------------------------------------------------------------
module row_checker
  import row_checker_pkg::*;
#(
  parameter int BOARD_W = row_checker_pkg::BOARD_W,
  parameter int BOARD_H = row_checker_pkg::BOARD_H
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_check,
  input  logic [4:0] row,
  input  logic [2:0] read_id,
  output logic [4:0] read_x,
  output logic [4:0] read_y,
  output logic       rden,
  output logic       ready,
  output logic       fail_or_full,
  output logic       full
);

  localparam coord_t C_LAST_X = coord_t'(BOARD_W - 1);
  localparam coord_t C_ROWS   = coord_t'(BOARD_H);

  state_t r_state;
  logic   r_rden;
  logic   r_fail_or_full;
  logic   r_full;

  coord_t w_row_q;
  coord_t w_x;
  logic   w_valid;
  coord_t w_tag;

  logic w_row_legal;
  logic w_load;
  logic w_abort;
  logic w_last;
  logic w_advance;

  assign w_row_legal = (row < C_ROWS);
  assign w_load      = (r_state == ST_IDLE) && start_check && w_row_legal;
  assign w_abort     = (r_state != ST_IDLE) && w_valid && (read_id == EMPTY_ID);
  assign w_last      = (w_x == C_LAST_X);
  assign w_advance   = (r_state == ST_SCAN) && !w_abort && !w_last;

  row_checker_data u_data (
    .clk     (clk),
    .reset   (reset),
    .load    (w_load),
    .advance (w_advance),
    .abort   (w_abort),
    .rden    (r_rden),
    .row     (row),
    .row_q   (w_row_q),
    .x       (w_x),
    .valid_q (w_valid),
    .tag_q   (w_tag)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_rden         <= 1'b0;
      r_fail_or_full <= 1'b0;
      r_full         <= 1'b0;
    end else begin
      r_fail_or_full <= 1'b0;
      r_full         <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start_check) begin
            if (w_row_legal) begin
              r_state <= ST_SCAN;
              r_rden  <= 1'b1;
            end else begin
              r_fail_or_full <= 1'b1;
            end
          end
        end
        ST_SCAN: begin
          if (w_abort) begin
            r_state        <= ST_IDLE;
            r_rden         <= 1'b0;
            r_fail_or_full <= 1'b1;
          end else if (w_last) begin
            r_state <= ST_DRAIN;
            r_rden  <= 1'b0;
          end
        end
        ST_DRAIN: begin
          // Only the final column's read can still be outstanding here.
          r_state        <= ST_IDLE;
          r_fail_or_full <= 1'b1;
          r_full         <= w_valid && (w_tag == C_LAST_X) && (read_id != EMPTY_ID);
        end
        default: begin
          r_state <= ST_IDLE;
          r_rden  <= 1'b0;
        end
      endcase
    end
  end

  assign read_x       = w_x;
  assign read_y       = w_row_q;
  assign rden         = r_rden;
  assign ready        = (r_state == ST_IDLE);
  assign fail_or_full = r_fail_or_full;
  assign full         = r_full;

endmodule
`default_nettype wire
